// File: rtl/i2c_sensor_seq.sv
// Register-sensor sequencer for I2C_Master: optional config write, settle wait,
// register-pointer write, then a READ_BYTES burst read into Data_o (first byte in MSBs).
module i2c_sensor_seq #(
  parameter int READ_BYTES  = 2,
  parameter int TIMER_WIDTH = 16
) (
  input  logic                     Clk_i,
  input  logic                     Reset_i,
  input  logic                     Start_i,
  input  logic                     SkipConfig_i,
  input  logic [6:0]               DevAddr_i,
  input  logic [7:0]               ConfigReg_i,
  input  logic [7:0]               ConfigVal_i,
  input  logic [7:0]               DataReg_i,
  input  logic [TIMER_WIDTH-1:0]   ParamCounterPreset_i,
  output logic                     Done_o,
  output logic                     Error_o,
  output logic                     Busy_o,
  output logic [8*READ_BYTES-1:0]  Data_o,
  output logic                     I2C_ReceiveSend_n_o,
  output logic [7:0]               I2C_ReadCount_o,
  output logic                     I2C_StartProcess_o,
  input  logic                     I2C_Busy_i,
  output logic                     I2C_FIFOReadNext_o,
  output logic                     I2C_FIFOWrite_o,
  output logic [7:0]               I2C_Data_o,
  input  logic [7:0]               I2C_Data_i,
  input  logic                     I2C_Error_i
);

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_WR_CFG_REG  = 4'd1,
    ST_WR_CFG_VAL  = 4'd2,
    ST_START_CFG   = 4'd3,
    ST_WAIT_CFG    = 4'd4,
    ST_WAIT        = 4'd5,
    ST_WR_PTR_REG  = 4'd6,
    ST_START_PTR   = 4'd7,
    ST_WAIT_PTR    = 4'd8,
    ST_START_RD    = 4'd9,
    ST_WAIT_RD     = 4'd10,
    ST_READ        = 4'd11,
    ST_DONE        = 4'd12
  } state_t;

  localparam logic [7:0] RD_CNT   = 8'(READ_BYTES);
  localparam logic [3:0] LAST_IDX = 4'(READ_BYTES - 1);

  state_t                    r_state;
  state_t                    w_next;
  logic [TIMER_WIDTH-1:0]    r_timer;
  logic [3:0]                r_idx;
  logic [8*READ_BYTES-1:0]   r_data;
  logic                      w_cap;
  logic [3:0]                w_cap_idx;
  logic                      w_timer_zero;

  assign w_timer_zero = (r_timer == '0);
  assign Data_o       = r_data;

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Reset value is irrelevant beyond Idle: every non-Wait cycle reloads the preset,
  // and Wait is only entered from a state that has already done so.
  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      r_timer <= '0;
    end else if (r_state == ST_WAIT && !w_timer_zero) begin
      r_timer <= r_timer - TIMER_WIDTH'(1);
    end else begin
      r_timer <= ParamCounterPreset_i;
    end
  end

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      r_idx <= 4'd0;
    end else if (w_cap) begin
      r_idx <= w_cap_idx + 4'd1;
    end else begin
      r_idx <= 4'd0;
    end
  end

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      r_data <= '0;
    end else if (w_cap) begin
      for (int k = 0; k < READ_BYTES; k++) begin
        if (w_cap_idx == 4'(k)) begin
          r_data[8*(READ_BYTES-k)-1 -: 8] <= I2C_Data_i;
        end
      end
    end
  end

  always_comb begin
    w_next              = r_state;
    w_cap               = 1'b0;
    w_cap_idx           = 4'd0;
    Done_o              = 1'b0;
    Error_o             = 1'b0;
    Busy_o              = (r_state != ST_IDLE);
    I2C_ReceiveSend_n_o = 1'b0;
    I2C_ReadCount_o     = 8'd0;
    I2C_StartProcess_o  = 1'b0;
    I2C_FIFOReadNext_o  = 1'b0;
    I2C_FIFOWrite_o     = 1'b0;
    I2C_Data_o          = 8'd0;
    case (r_state)
      ST_IDLE: begin
        if (Start_i) begin
          I2C_FIFOWrite_o = 1'b1;
          I2C_Data_o      = {DevAddr_i, 1'b0};
          w_next          = SkipConfig_i ? ST_WR_PTR_REG : ST_WR_CFG_REG;
        end
      end
      ST_WR_CFG_REG: begin
        I2C_FIFOWrite_o = 1'b1;
        I2C_Data_o      = ConfigReg_i;
        w_next          = ST_WR_CFG_VAL;
      end
      ST_WR_CFG_VAL: begin
        I2C_FIFOWrite_o = 1'b1;
        I2C_Data_o      = ConfigVal_i;
        w_next          = ST_START_CFG;
      end
      ST_START_CFG: begin
        I2C_StartProcess_o = 1'b1;
        w_next             = ST_WAIT_CFG;
      end
      ST_WAIT_CFG: begin
        if (I2C_Error_i) begin
          Error_o = 1'b1;
          w_next  = ST_IDLE;
        end else if (!I2C_Busy_i) begin
          w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_timer_zero) begin
          I2C_FIFOWrite_o = 1'b1;
          I2C_Data_o      = {DevAddr_i, 1'b0};
          w_next          = ST_WR_PTR_REG;
        end
      end
      ST_WR_PTR_REG: begin
        I2C_FIFOWrite_o = 1'b1;
        I2C_Data_o      = DataReg_i;
        w_next          = ST_START_PTR;
      end
      ST_START_PTR: begin
        I2C_StartProcess_o = 1'b1;
        w_next             = ST_WAIT_PTR;
      end
      ST_WAIT_PTR: begin
        if (I2C_Error_i) begin
          Error_o = 1'b1;
          w_next  = ST_IDLE;
        end else if (!I2C_Busy_i) begin
          I2C_FIFOWrite_o = 1'b1;
          I2C_Data_o      = {DevAddr_i, 1'b1};
          w_next          = ST_START_RD;
        end
      end
      ST_START_RD: begin
        I2C_ReceiveSend_n_o = 1'b1;
        I2C_ReadCount_o     = RD_CNT;
        I2C_StartProcess_o  = 1'b1;
        w_next              = ST_WAIT_RD;
      end
      ST_WAIT_RD: begin
        I2C_ReceiveSend_n_o = 1'b1;
        I2C_ReadCount_o     = RD_CNT;
        if (I2C_Error_i) begin
          Error_o = 1'b1;
          w_next  = ST_IDLE;
        end else if (!I2C_Busy_i) begin
          I2C_FIFOReadNext_o = 1'b1;
          w_cap              = 1'b1;
          w_cap_idx          = 4'd0;
          w_next             = (READ_BYTES == 1) ? ST_DONE : ST_READ;
        end
      end
      // Pops continue back-to-back; r_idx names the byte at the FIFO head this cycle.
      ST_READ: begin
        I2C_FIFOReadNext_o = 1'b1;
        w_cap              = 1'b1;
        w_cap_idx          = r_idx;
        if (r_idx == LAST_IDX) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        Done_o = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_sensor_seq.sv
// Scoreboard bench for i2c_sensor_seq: READ_BYTES=2 and READ_BYTES=4 instances share a
// behavioural I2C_Master model; a negedge monitor pops expected FIFO pushes and results.
module tb_i2c_sensor_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        skip, start2, start4;
  logic [6:0]  dev;
  logic [7:0]  cfg_reg, cfg_val, data_reg;
  logic [15:0] preset;
  logic        m_busy, m_err;
  logic [7:0]  m_rx;

  logic        done2, err2, busy2, rs2, sp2, rn2, fw2;
  logic [15:0] data2;
  logic [7:0]  rc2, d2;
  logic        done4, err4, busy4, rs4, sp4, rn4, fw4;
  logic [31:0] data4;
  logic [7:0]  rc4, d4;

  i2c_sensor_seq #(.READ_BYTES(2), .TIMER_WIDTH(16)) dut2 (
    .Clk_i(clk), .Reset_i(rst), .Start_i(start2), .SkipConfig_i(skip), .DevAddr_i(dev),
    .ConfigReg_i(cfg_reg), .ConfigVal_i(cfg_val), .DataReg_i(data_reg),
    .ParamCounterPreset_i(preset), .Done_o(done2), .Error_o(err2), .Busy_o(busy2),
    .Data_o(data2), .I2C_ReceiveSend_n_o(rs2), .I2C_ReadCount_o(rc2),
    .I2C_StartProcess_o(sp2), .I2C_Busy_i(m_busy), .I2C_FIFOReadNext_o(rn2),
    .I2C_FIFOWrite_o(fw2), .I2C_Data_o(d2), .I2C_Data_i(m_rx), .I2C_Error_i(m_err));

  i2c_sensor_seq #(.READ_BYTES(4), .TIMER_WIDTH(16)) dut4 (
    .Clk_i(clk), .Reset_i(rst), .Start_i(start4), .SkipConfig_i(skip), .DevAddr_i(dev),
    .ConfigReg_i(cfg_reg), .ConfigVal_i(cfg_val), .DataReg_i(data_reg),
    .ParamCounterPreset_i(preset), .Done_o(done4), .Error_o(err4), .Busy_o(busy4),
    .Data_o(data4), .I2C_ReceiveSend_n_o(rs4), .I2C_ReadCount_o(rc4),
    .I2C_StartProcess_o(sp4), .I2C_Busy_i(m_busy), .I2C_FIFOReadNext_o(rn4),
    .I2C_FIFOWrite_o(fw4), .I2C_Data_o(d4), .I2C_Data_i(m_rx), .I2C_Error_i(m_err));

  // Master model: busy for 3 cycles after each start; optional error mid-transfer.
  logic [2:0] m_cnt;
  logic [7:0] rx_mem [0:7];
  int  pops = 0, pop_base = 0, cyc = 0;
  bit  inj_err = 0;
  wire sp = sp2 | sp4;
  wire rn = rn2 | rn4;
  assign m_rx = rx_mem[3'(pops - pop_base)];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (!rst && rn) pops <= pops + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0; m_cnt <= 3'd0; m_err <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (sp) begin
        m_busy <= 1'b1; m_cnt <= 3'd3;
      end else if (m_cnt != 3'd0) begin
        m_cnt <= m_cnt - 3'd1;
        if (m_cnt == 3'd1) m_busy <= 1'b0;
        if (m_cnt == 3'd2 && inj_err) m_err <= 1'b1;
      end
    end
  end

  int errors = 0, checks = 0;
  logic [7:0]  exp_push [$];
  logic [63:0] exp_done [$];
  int          exp_err = 0;
  logic [7:0]  exp_rc = 8'd2;
  int push_t [$];
  int fall_t [$];
  int n_push = 0, n_done = 0, n_errp = 0, n_sp = 0, run = 0, last_run = 0;
  logic busy_q = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0]  e8;
    logic [63:0] e64;
    if (!rst) begin
      if (fw2 || fw4) begin
        push_t.push_back(cyc);
        n_push++;
        if (exp_push.size() == 0) chk("unexpected_push", fw2 ? d2 : d4, 64'hFFFF);
        else begin
          e8 = exp_push.pop_front();
          chk("fifo_push", fw2 ? d2 : d4, e8);
        end
      end
      if (busy_q && !m_busy) fall_t.push_back(cyc);
      if (sp) n_sp++;
      if (sp && (rs2 || rs4)) chk("read_count", rs2 ? rc2 : rc4, exp_rc);
      if (rn) run++;
      else if (run != 0) begin last_run = run; run = 0; end
      if (done2 || done4) begin
        n_done++;
        if (exp_done.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          e64 = exp_done.pop_front();
          chk("data_out", done2 ? {48'd0, data2} : {32'd0, data4}, e64);
        end
      end
      if (err2 || err4) begin
        n_errp++;
        chk("error_pulse", (exp_err > 0) ? 64'd1 : 64'd0, 64'd1);
        if (exp_err > 0) exp_err--;
      end
    end
    busy_q = m_busy;
  end

  task automatic setup(input bit sk, input logic [6:0] dv, input logic [7:0] cr,
                       input logic [7:0] cv, input logic [7:0] dr, input logic [15:0] p);
    skip = sk; dev = dv; cfg_reg = cr; cfg_val = cv; data_reg = dr; preset = p;
  endtask

  task automatic load_rx(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    rx_mem[0] = b0; rx_mem[1] = b1; rx_mem[2] = b2; rx_mem[3] = b3;
    pop_base = pops;
  endtask

  task automatic pulse_start(input bit four);
    @(negedge clk);
    if (four) start4 = 1'b1; else start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; start4 = 1'b0;
  endtask

  task automatic wait_end(input int lim);
    int d0, e0;
    bit seen;
    d0 = n_done; e0 = n_errp; seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      @(posedge clk);
      if (n_done != d0 || n_errp != e0) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL timeout: sequence not finished within %0d cycles", lim);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int pb, fb, sp0, pp0, np0, ep0;
    rst = 1'b1; start2 = 0; start4 = 0;
    setup(0, 7'h48, 8'h03, 8'h20, 8'h00, 16'd3);
    load_rx(8'h00, 8'h00, 8'h00, 8'h00);
    #1;
    chk("reset_out_rb2", {done2, err2, busy2, data2, rs2, rc2, sp2, rn2, fw2, d2}, 64'd0);
    chk("reset_out_rb4", {done4, err4, busy4, data4, rs4, rc4, sp4, rn4, fw4, d4}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: full sequence with config, P=3
    setup(0, 7'h48, 8'h03, 8'h20, 8'h00, 16'd3);
    load_rx(8'h0C, 8'h80, 8'h00, 8'h00);
    exp_rc = 8'd2;
    foreach (exp_push[i]) ;
    exp_push = '{8'h90, 8'h03, 8'h20, 8'h90, 8'h00, 8'h91};
    exp_done.push_back(64'h0C80);
    pb = push_t.size(); fb = fall_t.size(); sp0 = n_sp;
    pulse_start(0);
    wait_end(200);
    chk("t1_wait_len", (push_t.size() > pb + 3 && fall_t.size() > fb) ? push_t[pb+3] - fall_t[fb] : -1, 64'd4);
    chk("t1_pop_run", last_run, 64'd2);
    chk("t1_pops", pops - pop_base, 64'd2);
    chk("t1_starts", n_sp - sp0, 64'd3);

    // 2: skip config
    setup(1, 7'h48, 8'h03, 8'h20, 8'h00, 16'd3);
    load_rx(8'h5A, 8'hA5, 8'h00, 8'h00);
    exp_push = '{8'h90, 8'h00, 8'h91};
    exp_done.push_back(64'h5AA5);
    sp0 = n_sp; np0 = n_push;
    pulse_start(0);
    wait_end(200);
    chk("t2_starts", n_sp - sp0, 64'd2);
    chk("t2_pushes", n_push - np0, 64'd3);

    // 3: P=0, different address/registers
    setup(0, 7'h1F, 8'h01, 8'hFF, 8'h07, 16'd0);
    load_rx(8'hDE, 8'hAD, 8'h00, 8'h00);
    exp_push = '{8'h3E, 8'h01, 8'hFF, 8'h3E, 8'h07, 8'h3F};
    exp_done.push_back(64'hDEAD);
    pb = push_t.size(); fb = fall_t.size();
    pulse_start(0);
    wait_end(200);
    chk("t3_wait_len", (push_t.size() > pb + 3 && fall_t.size() > fb) ? push_t[pb+3] - fall_t[fb] : -1, 64'd1);

    // 4: error during pointer transfer
    setup(1, 7'h48, 8'h03, 8'h20, 8'h00, 16'd3);
    load_rx(8'h77, 8'h66, 8'h00, 8'h00);
    inj_err = 1;
    exp_push = '{8'h90, 8'h00};
    exp_err = 1;
    sp0 = n_sp; ep0 = n_errp;
    pulse_start(0);
    wait_end(200);
    inj_err = 0;
    chk("t4_data_kept", data2, 64'hDEAD);
    chk("t4_starts", n_sp - sp0, 64'd1);
    chk("t4_no_pops", pops - pop_base, 64'd0);
    chk("t4_err_len", n_errp - ep0, 64'd1);
    chk("t4_idle", busy2, 64'd0);
    repeat (6) @(negedge clk);

    // 5: four-byte instance
    setup(0, 7'h50, 8'h10, 8'h33, 8'h05, 16'd2);
    load_rx(8'h11, 8'h22, 8'h33, 8'h44);
    exp_rc = 8'd4;
    exp_push = '{8'hA0, 8'h10, 8'h33, 8'hA0, 8'h05, 8'hA1};
    exp_done.push_back(64'h11223344);
    pb = push_t.size(); fb = fall_t.size();
    pulse_start(1);
    wait_end(200);
    chk("t5_pop_run", last_run, 64'd4);
    chk("t5_pops", pops - pop_base, 64'd4);
    chk("t5_wait_len", (push_t.size() > pb + 3 && fall_t.size() > fb) ? push_t[pb+3] - fall_t[fb] : -1, 64'd3);
    chk("t5_rb2_untouched", data2, 64'hDEAD);
    exp_rc = 8'd2;

    // 6: reset while in Wait, then Start_i ignored mid-sequence
    setup(0, 7'h48, 8'h03, 8'h20, 8'h00, 16'd20);
    exp_push = '{8'h90, 8'h03, 8'h20};
    fb = fall_t.size();
    pulse_start(0);
    for (int i = 0; i < 50 && fall_t.size() == fb; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_reset_out", {done2, err2, busy2, data2, rs2, rc2, sp2, rn2, fw2, d2}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("t6_queue_drained", exp_push.size(), 64'd0);
    repeat (30) @(negedge clk);
    chk("t6_still_idle", {busy2, data2}, 64'd0);
    setup(1, 7'h48, 8'h03, 8'h20, 8'h00, 16'd3);
    load_rx(8'hBE, 8'hEF, 8'h00, 8'h00);
    exp_push = '{8'h90, 8'h00, 8'h91};
    exp_done.push_back(64'hBEEF);
    np0 = n_push;
    pulse_start(0);
    repeat (2) @(negedge clk);
    start2 = 1'b1;
    repeat (2) @(negedge clk);
    start2 = 1'b0;
    wait_end(200);
    repeat (10) @(negedge clk);
    chk("t6_pushes", n_push - np0, 64'd3);

    chk("end_push_queue", exp_push.size(), 64'd0);
    chk("end_done_queue", exp_done.size(), 64'd0);
    chk("end_err_pending", exp_err, 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
